// File: rtl/gbuf_arbiter_pkg.sv
// Shared constants and types for the global-buffer arbiter.
// Holds SRAM geometry, requester ids and the arbiter FSM encoding.
package gbuf_arbiter_pkg;

    localparam int SRAM_DEPTH  = 4096;
    localparam int SRAM_ADDR_W = 12;
    localparam int INT_WIDTH   = 8;

    localparam int GB_NUM_REQ = 3;
    localparam int GB_RD_LAT  = 1;

    localparam int GB_REQ_IFMAP  = 0;
    localparam int GB_REQ_WEIGHT = 1;
    localparam int GB_REQ_OFMAP  = 2;

    typedef logic [SRAM_ADDR_W-1:0] gb_addr_t;

    typedef enum logic {
        GB_IDLE = 1'b0,
        GB_BUSY = 1'b1
    } gb_state_t;

    // Width of a requester index; never below one bit so single-requester builds stay legal.
    function automatic int gb_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gbuf_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first requester found when
// scanning upward from last_owner+1 (wrapping) wins.
module gb_rr_pick
    import gbuf_arbiter_pkg::*;
#(
    parameter int NUM_REQ = GB_NUM_REQ,
    parameter int ID_W    = gb_id_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester at rotation offset gi+1; one spare bit absorbs the wrap.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum           = {1'b0, last_owner} + (ID_W+1)'(gi + 1);
        assign cand_idx[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ?
                               ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
        assign cand_hit[gi]  = req[cand_idx[gi]];
    end

    assign found = |cand_hit;

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/gbuf_arbiter.sv
// Round-robin burst arbiter in front of the single-port global buffer SRAM.
// The owner holds the SRAM until its last beat; read data is routed back by a tagged pipe.
module gbuf_arbiter
    import gbuf_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = GB_NUM_REQ,
    parameter  int ADDR_W  = SRAM_ADDR_W,
    parameter  int DATA_W  = INT_WIDTH,
    parameter  int RD_LAT  = GB_RD_LAT,
    localparam int OWN_W   = gb_id_width(NUM_REQ)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata,
    output logic                      busy,
    output logic [OWN_W-1:0]          owner
);

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    gb_state_t        state_reg, state_next;
    logic [OWN_W-1:0] owner_reg, owner_next;
    logic [OWN_W-1:0] last_owner_reg, last_owner_next;

    logic             pick_found;
    logic [OWN_W-1:0] pick_winner;

    logic owner_valid, owner_we, owner_last, beat_acc;

    gb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (OWN_W)
    ) u_pick (
        .req        (req_valid),
        .last_owner (last_owner_reg),
        .found      (pick_found),
        .winner     (pick_winner)
    );

    assign owner_valid = req_valid[owner_reg];
    assign owner_we    = req_we[owner_reg];
    assign owner_last  = req_last[owner_reg];

    // Gating with rst_n keeps the SRAM quiet during the reset cycle of an aborted burst.
    assign beat_acc = (state_reg == GB_BUSY) && rst_n && owner_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= GB_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OWN_W'(NUM_REQ - 1);
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            GB_IDLE: begin
                if (pick_found) begin
                    state_next      = GB_BUSY;
                    owner_next      = pick_winner;
                    last_owner_next = pick_winner;
                end
            end
            GB_BUSY: begin
                if (beat_acc && owner_last) begin
                    state_next = GB_IDLE;
                end
            end
            default: state_next = GB_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if ((state_reg == GB_BUSY) && rst_n) begin
            req_ready[owner_reg] = 1'b1;
        end
        if (beat_acc) begin
            sram_en    = 1'b1;
            sram_we    = owner_we;
            sram_addr  = addr_arr[owner_reg];
            sram_wdata = wdata_arr[owner_reg];
        end
    end

    assign busy  = (state_reg == GB_BUSY);
    assign owner = owner_reg;

    // Each stage carries (valid, requester id) so returns survive an owner change.
    logic             pipe_valid_reg [RD_LAT];
    logic [OWN_W-1:0] pipe_id_reg    [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_id_reg[i]    <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= beat_acc && !owner_we;
            pipe_id_reg[0]    <= owner_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_id_reg[i]    <= pipe_id_reg[i-1];
            end
        end
    end

    logic             pipe_out_valid;
    logic [OWN_W-1:0] pipe_out_id;

    assign pipe_out_valid = pipe_valid_reg[RD_LAT-1];
    assign pipe_out_id    = pipe_id_reg[RD_LAT-1];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
        assign rsp_valid[gi] = pipe_out_valid && (pipe_out_id == OWN_W'(gi));
    end

    assign rsp_rdata = pipe_out_valid ? sram_rdata : '0;

endmodule

// File: tb/tb_gbuf_arbiter.sv
// Directed bench for gbuf_arbiter with a behavioural 1-cycle-latency SRAM.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_gbuf_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_valid, req_ready, req_we, req_last, rsp_valid;
    logic [35:0]  req_addr;
    logic [23:0]  req_wdata;
    logic [7:0]   rsp_rdata;
    logic         sram_en, sram_we;
    logic [11:0]  sram_addr;
    logic [7:0]   sram_wdata;
    logic [7:0]   sram_rdata = '0;
    logic         busy;
    logic [1:0]   owner;

    logic [7:0]   mem [4096];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en && sram_we)  mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata     <= mem[sram_addr];
    end

    gbuf_arbiter #(
        .NUM_REQ (3),
        .ADDR_W  (12),
        .DATA_W  (8),
        .RD_LAT  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_last   (req_last),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy),
        .owner      (owner)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        logic [31:0] e;
        e = exp;
        n_total++;
        assert (obs === e) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
        end
    endtask

    task automatic drive(input int id, input bit v, input bit we, input bit last,
                         input int addr, input int data);
        req_valid[id]           = v;
        req_we[id]              = we;
        req_last[id]            = last;
        req_addr[id*12 +: 12]   = 12'(addr);
        req_wdata[id*8 +: 8]    = 8'(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick;
        tick;

        // Reset state
        chk("rst_busy",   32'(busy),       0);
        chk("rst_owner",  32'(owner),      0);
        chk("rst_ready",  32'(req_ready),  0);
        chk("rst_rsp",    32'(rsp_valid),  0);
        chk("rst_rdata",  32'(rsp_rdata),  0);
        chk("rst_en",     32'(sram_en),    0);
        chk("rst_we",     32'(sram_we),    0);
        chk("rst_addr",   32'(sram_addr),  0);
        chk("rst_wdata",  32'(sram_wdata), 0);
        rst_n = 1'b1;
        $display("reset released");

        // Requester 1: 4-beat write burst to 0x010..0x013
        drive(1, 1, 1, 0, 'h010, 'hA0);
        settle;
        chk("t1_pre_busy",  32'(busy),      0);
        chk("t1_pre_ready", 32'(req_ready), 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            drive(1, 1, 1, (k == 3), 'h010 + k, 'hA0 + k);
            settle;
            chk("t1_ready", 32'(req_ready),  'b010);
            chk("t1_owner", 32'(owner),      1);
            chk("t1_en",    32'(sram_en),    1);
            chk("t1_we",    32'(sram_we),    1);
            chk("t1_addr",  32'(sram_addr),  'h010 + k);
            chk("t1_wdata", 32'(sram_wdata), 'hA0 + k);
            $display("t1 write beat %0d addr=0x%03h data=0x%02h", k, sram_addr, sram_wdata);
        end
        tick;
        drive(1, 0, 0, 0, 0, 0);
        settle;
        chk("t1_post_busy", 32'(busy),    0);
        chk("t1_post_en",   32'(sram_en), 0);
        tick;
        chk("t1_post2_busy",  32'(busy),      0);
        chk("t1_post2_ready", 32'(req_ready), 0);

        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;

        // Three requesters, single-beat bursts, three rounds
        for (int id = 0; id < 3; id++) drive(id, 1, 1, 1, 'h200 + id, 'h50 + id);
        for (int g = 0; g < 9; g++) begin
            settle;
            chk("t2_idle_ready", 32'(req_ready), 0);
            tick;
            settle;
            chk("t2_owner", 32'(owner),     g % 3);
            chk("t2_ready", 32'(req_ready), 1 << (g % 3));
            $display("t2 grant %0d owner=%0d ready=%b", g, owner, req_ready);
            tick;
        end
        req_valid = '0;

        // Requester 0 reads back the burst written by requester 1
        drive(0, 1, 0, 0, 'h010, 0);
        settle;
        for (int k = 0; k < 4; k++) begin
            tick;
            drive(0, 1, 0, (k == 3), 'h010 + k, 0);
            settle;
            chk("t3_ready", 32'(req_ready), 'b001);
            chk("t3_en",    32'(sram_en),   1);
            chk("t3_we",    32'(sram_we),   0);
            chk("t3_addr",  32'(sram_addr), 'h010 + k);
            if (k > 0) begin
                chk("t3_rsp",   32'(rsp_valid), 'b001);
                chk("t3_rdata", 32'(rsp_rdata), 'hA0 + k - 1);
            end else begin
                chk("t3_rsp_first", 32'(rsp_valid), 0);
            end
            $display("t3 read beat %0d addr=0x%03h rsp=%b data=0x%02h", k, sram_addr, rsp_valid, rsp_rdata);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0);
        settle;
        chk("t3_rsp_last",   32'(rsp_valid), 'b001);
        chk("t3_rdata_last", 32'(rsp_rdata), 'hA3);
        chk("t3_busy",       32'(busy),      0);
        tick;
        chk("t3_rsp_done",   32'(rsp_valid), 0);

        // Owner 2 stalls mid-burst while requester 0 waits
        drive(2, 1, 1, 0, 'h300, 'h11);
        drive(0, 1, 1, 1, 'h310, 'h55);
        settle;
        tick;
        settle;
        chk("t4_owner", 32'(owner),     2);
        chk("t4_ready", 32'(req_ready), 'b100);
        chk("t4_addr",  32'(sram_addr), 'h300);
        tick;
        drive(2, 0, 1, 0, 'h301, 'h12);
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("t4_gap_owner", 32'(owner),     2);
            chk("t4_gap_ready", 32'(req_ready), 'b100);
            chk("t4_gap_en",    32'(sram_en),   0);
            $display("t4 bubble %0d owner=%0d en=%b", i, owner, sram_en);
            tick;
        end
        drive(2, 1, 1, 1, 'h301, 'h12);
        settle;
        chk("t4_last_en",   32'(sram_en),   1);
        chk("t4_last_addr", 32'(sram_addr), 'h301);
        tick;
        drive(2, 0, 0, 0, 0, 0);
        settle;
        chk("t4_gap_busy",  32'(busy),      0);
        chk("t4_gap_ready0", 32'(req_ready), 0);
        tick;
        settle;
        chk("t4_next_owner", 32'(owner),     0);
        chk("t4_next_ready", 32'(req_ready), 'b001);
        chk("t4_next_addr",  32'(sram_addr), 'h310);
        $display("t4 requester 0 granted after owner 2 finished");
        tick;
        drive(0, 0, 0, 0, 0, 0);

        // Read as last beat, then a new grant while the response returns
        drive(1, 1, 0, 1, 'h011, 0);
        drive(2, 1, 1, 1, 'h320, 'h77);
        settle;
        tick;
        settle;
        chk("t5_owner", 32'(owner),     1);
        chk("t5_ready", 32'(req_ready), 'b010);
        chk("t5_we",    32'(sram_we),   0);
        tick;
        drive(1, 0, 0, 0, 0, 0);
        settle;
        chk("t5_rsp",   32'(rsp_valid), 'b010);
        chk("t5_rdata", 32'(rsp_rdata), 'hA1);
        chk("t5_busy",  32'(busy),      0);
        tick;
        settle;
        chk("t5_new_owner", 32'(owner),     2);
        chk("t5_new_ready", 32'(req_ready), 'b100);
        chk("t5_rsp_done",  32'(rsp_valid), 0);
        $display("t5 response routed to 1, new owner=%0d", owner);
        tick;
        drive(2, 0, 0, 0, 0, 0);

        // Reset in the middle of a read burst
        drive(1, 1, 0, 0, 'h010, 0);
        settle;
        tick;
        settle;
        chk("t6_owner", 32'(owner), 1);
        tick;
        drive(1, 1, 0, 0, 'h011, 0);
        rst_n = 1'b0;
        settle;
        chk("t6_rst_cycle_en", 32'(sram_en), 0);
        tick;
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        settle;
        chk("t6_busy",  32'(busy),       0);
        chk("t6_owner0", 32'(owner),     0);
        chk("t6_ready", 32'(req_ready),  0);
        chk("t6_rsp",   32'(rsp_valid),  0);
        chk("t6_rdata", 32'(rsp_rdata),  0);
        chk("t6_en",    32'(sram_en),    0);
        chk("t6_we",    32'(sram_we),    0);
        chk("t6_addr",  32'(sram_addr),  0);
        chk("t6_wdata", 32'(sram_wdata), 0);
        drive(0, 1, 1, 1, 'h330, 'h01);
        drive(1, 1, 1, 1, 'h331, 'h02);
        settle;
        tick;
        settle;
        chk("t6_win_owner", 32'(owner),     0);
        chk("t6_win_ready", 32'(req_ready), 'b001);
        $display("t6 post-reset contest owner=%0d", owner);
        tick;
        req_valid = '0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gbuf_arbiter.md
# gbuf_arbiter

Round-robin arbiter that shares the single-port global buffer SRAM (SRAM_DEPTH words of INT_WIDTH bits) between the accelerator's requesters: the input loader, the weight loader and the output writeback. Each requester holds the SRAM for a locked burst, delimited by `req_last`. Read data returns to the owning requester after a fixed SRAM latency. The block sits between the load/store engines and the SRAM macro and is the only master driving the SRAM pins.

## Interface
- NUM_REQ, 3, number of requesters (≥1)
- ADDR_W, SRAM_ADDR_W (12), SRAM word address width
- DATA_W, INT_WIDTH (8), SRAM word width
- RD_LAT, 1, SRAM read latency in cycles (≥1)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accepted
- req_we  in  NUM_REQ  1 = write beat, 0 = read beat
- req_last  in  NUM_REQ  final beat of burst
- req_addr  in  NUM_REQ×ADDR_W  packed beat addresses
- req_wdata  in  NUM_REQ×DATA_W  packed write data
- rsp_valid  out  NUM_REQ  read data valid, one-hot
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after `sram_en` with `sram_we` = 0
- busy  out  1  a burst is granted
- owner  out  $clog2(NUM_REQ) (min 1)  index of the current owner

## Operation
- FSM states:
  - IDLE: if any `req_valid` is high, pick a winner → BUSY, register `owner`; otherwise stay in IDLE.
  - BUSY: `req_ready[owner]` = 1; all other ready bits are 0.
  - BUSY → IDLE on the cycle a beat with `req_valid[owner] & req_last[owner]` is accepted.
- Arbitration: round-robin. The search starts at `(last_owner+1) mod NUM_REQ`. `last_owner` updates on grant. Its reset value is NUM_REQ-1, so requester 0 wins the first contest.
- Beat acceptance = `req_valid[owner] & req_ready[owner]`. On an accepted beat:
  - `sram_en` = 1 and `sram_we` = `req_we[owner]`.
  - `sram_addr` and `sram_wdata` are taken from the owner's slice.
  - All SRAM outputs are combinational from the owner's request.
  - Outside an accepted beat, `sram_en` = 0 and `sram_we` = 0.
- Read return:
  - Each accepted read pushes (valid, owner) into an RD_LAT-deep shift pipe.
  - At the pipe output, `rsp_valid[id]` = 1 and `rsp_rdata` = `sram_rdata`.
  - There is no response backpressure; requesters must sink responses.
- Writes produce no response.
- Mixed read and write beats within one burst are legal.
- Owner deasserts `req_valid` mid-burst: the grant is held and bubble cycles occur. There is no timeout.
- Non-owner requests wait; their `req_valid` must stay high (AXI-style stability). Non-owners are never dropped.
- Addresses are used as-is. ADDR_W matches SRAM_DEPTH, so there is no range check.
- NUM_REQ = 1: the arbiter degenerates to a pass-through with a 1-cycle grant gap per burst.

## Timing
- Reset (`rst_n` low at an edge):
  - state = IDLE, `busy` = 0, `owner` = 0, `last_owner` = NUM_REQ-1.
  - Response pipe cleared, so in-flight reads are dropped with no `rsp_valid`.
  - All outputs are 0 from the first post-reset cycle.
- Reset mid-burst aborts the burst; no SRAM access issues in the reset cycle.
- Grant latency: a request seen in IDLE at edge N gives `busy` = 1 and `req_ready` = 1 in cycle N+1.
- Minimum burst overhead is 1 idle cycle: after the last beat at edge M, state is IDLE in cycle M+1 and the new owner is ready in M+2.
- A single-beat burst (`req_last` with the first beat) occupies 1 BUSY cycle.
- Read response: accepted at cycle T → `rsp_valid` at cycle T+RD_LAT. Throughput is 1 beat/cycle within a burst.
- Responses from an old owner may overlap a new grant; they are routed by the pipe id, not by `owner`.

## Structure
- Add to the `definitions` package:
  - `GB_NUM_REQ` = 3 and `GB_RD_LAT` = 1.
  - Requester ids `GB_REQ_IFMAP` = 0, `GB_REQ_WEIGHT` = 1, `GB_REQ_OFMAP` = 2.
  - `typedef logic [SRAM_ADDR_W-1:0] gb_addr_t`.
- Sub-module `gb_rr_pick`: combinational rotate-priority picker with inputs (req vector, last_owner) and outputs (found, winner index).
- FSM, slice mux and response pipe live in `gbuf_arbiter`.

## Test plan
- Reset, then requester 1 issues a 4-beat write to 0x010–0x013 (data 0xA0–0xA3) → grant in cycle 1 after valid; `sram_we` = 1 on 4 consecutive cycles; `busy` = 0 two cycles after the last beat.
- All 3 requesters request simultaneously, each with 1-beat bursts, 3 rounds → grant order 0,1,2,0,1,2,0,1,2; never two ready bits high.
- Requester 0 reads 0x010–0x013 after the first test's writes → `rsp_valid[0]` RD_LAT cycles after each beat with data 0xA0–0xA3; `rsp_valid[1]` and `rsp_valid[2]` stay 0.
- Owner 2 drops `req_valid` for 3 cycles mid-burst while requester 0 is waiting → `owner` stays 2, `sram_en` = 0 during the gap, requester 0 is granted only after the last beat of 2.
- Read issued as the last beat, immediately followed by a new grant to another requester → the response is routed to the original requester despite the `owner` change.
- `rst_n` asserted mid-burst with a read in flight → no `rsp_valid`, all outputs 0; the next contest is won by requester 0.
